packer_ctrl: RTL and testbench

- Sequences a 2-row packing register datapath (2*BIT_WIDTH bits, low row = bits W-1:0, high row = bits 2W-1:W, W = BIT_WIDTH).
- Accepts a stream of reduced-precision values from the pipeline and computes, per accepted value, the shift amount and the per-bit load enables.
- Tracks which rows are full and presents completed rows to the downstream writer via a valid/ready handshake, using the row-select output.
- Supports flushing a partial final row.

---
 rtl/packer_ctrl.sv | 144 ++++++++++++++
 tb/tb_packer_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/packer_ctrl.sv
// packer_ctrl: sequences a 2-row packing register (2*BIT_WIDTH bits). For each
// accepted value it produces the shift amount and the per-bit load enables,
// tracks which rows are full, and hands completed rows (oldest first) to the
// downstream writer over a valid/ready handshake. A flush emits a partial row.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   i_valid/i_prec  upstream value valid and its precision P
//   o_ready         value can be accepted this cycle
//   i_flush         emit the partial current row
//   o_s, o_load     shift amount and per-bit load enables for the datapath
//   o_row_sel       row presented downstream (0 = low, 1 = high)
//   o_valid/i_ready downstream row handshake
//   o_fill          valid LSBs in the presented row (W for a full row)
//   o_flush_done    one-cycle pulse when a flush completes
//
// Optional (macro PACKER_CTRL_STATS_EN): o_rows_out, o_stall_cycles saturating
// 32-bit counters of rows handed off and of stalled input cycles.
module packer_ctrl #(
    parameter int BIT_WIDTH  = 16,
    parameter int SHIFT_BITS = 5,
    parameter int PREC_BITS  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    input  logic [PREC_BITS-1:0]    i_prec,
    output logic                    o_ready,
    input  logic                    i_flush,
    output logic [SHIFT_BITS-1:0]   o_s,
    output logic [2*BIT_WIDTH-1:0]  o_load,
    output logic                    o_row_sel,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [SHIFT_BITS-1:0]   o_fill,
`ifdef PACKER_CTRL_STATS_EN
    output logic [31:0]             o_rows_out,
    output logic [31:0]             o_stall_cycles,
`endif
    output logic                    o_flush_done
);
    localparam int W  = BIT_WIDTH;
    localparam int W2 = 2 * BIT_WIDTH;
    localparam logic [W2-1:0] ONE = 1;

    typedef enum logic [1:0] {RUN, FLUSH_WAIT, FLUSH_EMIT} state_t;

    state_t                state, state_nxt;
    logic [SHIFT_BITS-1:0] ptr, ptr_nxt, nptr;
    logic [1:0]            pend, pend_nxt, part, part_nxt;
    logic                  head;   // oldest pending row; rows complete in ring order
    logic [SHIFT_BITS-1:0] fill, fill_nxt;
    logic [SHIFT_BITS-1:0] pe;
    logic [W2-1:0]         base, cand;
    logic [2*W2-1:0]       dbl;
    logic                  touches, fire, release_row;

    // Effective precision clamps to one row.
    assign pe = (int'(i_prec) > W) ? SHIFT_BITS'(W) : SHIFT_BITS'(i_prec);

    // Rotate-left of the Pe-bit mask by ptr: the upper half of the doubled
    // word shifted left is the rotation, so the mask wraps 2W-1 -> 0.
    assign base = (ONE << pe) - ONE;
    assign dbl  = {base, base} << ptr;
    assign cand = dbl[2*W2-1:W2];

    assign touches = (pend[0] && (cand[W-1:0]  != '0)) ||
                     (pend[1] && (cand[W2-1:W] != '0));

    // Gated by rst_n so nothing is accepted while reset is held.
    assign o_ready     = rst_n && (state == RUN) && !touches;
    assign fire        = i_valid && o_ready;
    assign o_load      = fire ? cand : '0;
    assign o_s         = ptr;
    assign nptr        = fire ? ptr + pe : ptr;

    assign o_row_sel    = head;
    assign o_valid      = pend[head];
    assign o_fill       = !o_valid ? '0 : (part[head] ? fill : SHIFT_BITS'(W));
    assign o_flush_done = (state == FLUSH_EMIT);
    assign release_row  = o_valid && i_ready;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = nptr;
        pend_nxt  = pend;
        part_nxt  = part;
        fill_nxt  = fill;
        if (release_row) begin
            pend_nxt[head] = 1'b0;
            part_nxt[head] = 1'b0;
        end
        if (fire && cand[W-1])  pend_nxt[0] = 1'b1;
        if (fire && cand[W2-1]) pend_nxt[1] = 1'b1;
        case (state)
            RUN: begin
                if (i_flush) begin
                    state_nxt = FLUSH_WAIT;
                    // Flush acts on the post-write pointer.
                    if (nptr[SHIFT_BITS-2:0] != '0) begin
                        fill_nxt                  = {1'b0, nptr[SHIFT_BITS-2:0]};
                        pend_nxt[nptr[SHIFT_BITS-1]] = 1'b1;
                        part_nxt[nptr[SHIFT_BITS-1]] = 1'b1;
                        ptr_nxt = {~nptr[SHIFT_BITS-1], {(SHIFT_BITS-1){1'b0}}};
                    end
                end
            end
            FLUSH_WAIT: if (pend == 2'b00) state_nxt = FLUSH_EMIT;
            FLUSH_EMIT: state_nxt = RUN;
            default:    state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            ptr   <= '0;
            pend  <= '0;
            part  <= '0;
            fill  <= '0;
            head  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            pend  <= pend_nxt;
            part  <= part_nxt;
            fill  <= fill_nxt;
            if (release_row) head <= ~head;
        end
    end

`ifdef PACKER_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rows_out     <= '0;
            o_stall_cycles <= '0;
        end else begin
            if (release_row && (o_rows_out != '1))          o_rows_out     <= o_rows_out + 32'd1;
            if (i_valid && !o_ready && (o_stall_cycles != '1)) o_stall_cycles <= o_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_packer_ctrl.sv
// Directed self-checking bench for packer_ctrl (W=16). Inputs change just after
// the falling edge; outputs are checked 1 time unit later.
module tb_packer_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [4:0]  i_prec = '0;
    logic        o_ready;
    logic        i_flush = 1'b0;
    logic [4:0]  o_s;
    logic [31:0] o_load;
    logic        o_row_sel;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [4:0]  o_fill;
    logic        o_flush_done;
`ifdef PACKER_CTRL_STATS_EN
    logic [31:0] o_rows_out, o_stall_cycles;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    packer_ctrl dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_prec(i_prec),
        .o_ready(o_ready), .i_flush(i_flush), .o_s(o_s), .o_load(o_load),
        .o_row_sel(o_row_sel), .o_valid(o_valid), .i_ready(i_ready),
        .o_fill(o_fill),
`ifdef PACKER_CTRL_STATS_EN
        .o_rows_out(o_rows_out), .o_stall_cycles(o_stall_cycles),
`endif
        .o_flush_done(o_flush_done)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; i_valid = 1'b0; i_prec = '0; i_flush = 1'b0; i_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b1; i_prec = 5'd8;
        @(negedge clk); #1;
        total++; if (o_ready !== 1'b0) $display("FAIL rst_ready got=%b exp=0", o_ready); else passed++;
        total++; if (o_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", o_valid); else passed++;
        total++; if (o_load !== 32'h0) $display("FAIL rst_load got=%h exp=0", o_load); else passed++;
        total++; if ({o_s, o_row_sel, o_fill, o_flush_done} !== 12'h0)
            $display("FAIL rst_misc got=%h exp=0", {o_s, o_row_sel, o_fill, o_flush_done}); else passed++;
        apply_reset();
    endtask

    task automatic test_p8();
        logic [31:0] exp_load [4];
        exp_load[0] = 32'h000000FF; exp_load[1] = 32'h0000FF00;
        exp_load[2] = 32'h00FF0000; exp_load[3] = 32'hFF000000;
        apply_reset();
        i_ready = 1'b1; i_valid = 1'b1; i_prec = 5'd8;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (o_load !== exp_load[k]) $display("FAIL p8_load%0d got=%h exp=%h", k, o_load, exp_load[k]); else passed++;
            if (k == 2) begin
                total++; if (o_valid !== 1'b1 || o_row_sel !== 1'b0 || o_fill !== 5'd16)
                    $display("FAIL p8_low_valid got=%b/%b/%0d exp=1/0/16", o_valid, o_row_sel, o_fill); else passed++;
            end
            @(negedge clk);
        end
        i_valid = 1'b0; #1;
        total++; if (o_valid !== 1'b1 || o_row_sel !== 1'b1 || o_s !== 5'd0)
            $display("FAIL p8_high_valid got=%b/%b/%0d exp=1/1/0", o_valid, o_row_sel, o_s); else passed++;
        @(negedge clk); #1;
        total++; if (o_valid !== 1'b0) $display("FAIL p8_drained got=%b exp=0", o_valid); else passed++;
    endtask

    task automatic test_p5_wrap();
        apply_reset();
        i_ready = 1'b1; i_valid = 1'b1; i_prec = 5'd5;
        for (int k = 0; k < 6; k++) @(negedge clk);
        #1;
        total++; if (o_s !== 5'd30) $display("FAIL p5_ptr30 got=%0d exp=30", o_s); else passed++;
        total++; if (o_load !== 32'hC0000007) $display("FAIL p5_wrap_load got=%h exp=c0000007", o_load); else passed++;
        @(negedge clk);
        i_valid = 1'b0; #1;
        total++; if (o_s !== 5'd3) $display("FAIL p5_ptr3 got=%0d exp=3", o_s); else passed++;
        total++; if (o_valid !== 1'b1 || o_row_sel !== 1'b1)
            $display("FAIL p5_high_pend got=%b/%b exp=1/1", o_valid, o_row_sel); else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        i_ready = 1'b0; i_valid = 1'b1; i_prec = 5'd16;
        #1;
        total++; if (o_load !== 32'h0000FFFF) $display("FAIL bp_load0 got=%h exp=0000ffff", o_load); else passed++;
        @(negedge clk); #1;
        total++; if (o_load !== 32'hFFFF0000) $display("FAIL bp_load1 got=%h exp=ffff0000", o_load); else passed++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            total++; if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_row_sel !== 1'b0)
                $display("FAIL bp_stall%0d got=%b/%b/%b exp=0/1/0", k, o_ready, o_valid, o_row_sel); else passed++;
        end
        i_prec = 5'd0; #1;
        total++; if (o_ready !== 1'b1 || o_load !== 32'h0) $display("FAIL bp_p0 got=%b/%h exp=1/0", o_ready, o_load); else passed++;
        @(negedge clk);
        i_prec = 5'd16; i_ready = 1'b1; #1;
        total++; if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_row_sel !== 1'b0 || o_s !== 5'd0)
            $display("FAIL bp_rel_low got=%b/%b/%b/%0d exp=0/1/0/0", o_ready, o_valid, o_row_sel, o_s); else passed++;
        @(negedge clk);
        i_valid = 1'b0; #1;
        total++; if (o_ready !== 1'b1 || o_valid !== 1'b1 || o_row_sel !== 1'b1)
            $display("FAIL bp_rel_high got=%b/%b/%b exp=1/1/1", o_ready, o_valid, o_row_sel); else passed++;
        @(negedge clk); #1;
        total++; if (o_valid !== 1'b0) $display("FAIL bp_drained got=%b exp=0", o_valid); else passed++;
    endtask

    task automatic test_flush();
        int wait_cyc;
        apply_reset();
        i_ready = 1'b1; i_valid = 1'b1; i_prec = 5'd3;
        for (int k = 0; k < 3; k++) @(negedge clk);
        i_valid = 1'b0; i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0; #1;
        total++; if (o_valid !== 1'b1 || o_row_sel !== 1'b0 || o_fill !== 5'd9)
            $display("FAIL fl_partial got=%b/%b/%0d exp=1/0/9", o_valid, o_row_sel, o_fill); else passed++;
        total++; if (o_ready !== 1'b0 || o_s !== 5'd16)
            $display("FAIL fl_wait got=%b/%0d exp=0/16", o_ready, o_s); else passed++;
        wait_cyc = 0;
        while (o_flush_done !== 1'b1 && wait_cyc < 10) begin
            @(negedge clk); #1;
            wait_cyc++;
        end
        total++; if (wait_cyc !== 2) $display("FAIL fl_done_latency got=%0d exp=2", wait_cyc); else passed++;
        @(negedge clk);
        i_valid = 1'b1; i_prec = 5'd4; #1;
        total++; if (o_flush_done !== 1'b0 || o_load !== 32'h000F0000)
            $display("FAIL fl_next_load got=%b/%h exp=0/000f0000", o_flush_done, o_load); else passed++;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        i_ready = 1'b0; i_valid = 1'b1; i_prec = 5'd16;
        @(negedge clk);
        @(negedge clk);
        i_valid = 1'b0; #1;
        total++; if (o_valid !== 1'b1) $display("FAIL rm_pre_valid got=%b exp=1", o_valid); else passed++;
        rst_n = 1'b0; #1;
        total++; if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_s !== 5'd0 || o_row_sel !== 1'b0)
            $display("FAIL rm_async got=%b/%b/%0d/%b exp=0/0/0/0", o_valid, o_ready, o_s, o_row_sel); else passed++;
        @(negedge clk);
        rst_n = 1'b1; i_ready = 1'b1; i_valid = 1'b1; i_prec = 5'd4; #1;
        total++; if (o_load !== 32'h0000000F || o_valid !== 1'b0)
            $display("FAIL rm_after got=%h/%b exp=0000000f/0", o_load, o_valid); else passed++;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic test_prec_clamp();
        apply_reset();
        i_ready = 1'b1; i_valid = 1'b1; i_prec = 5'd20; #1;
        total++; if (o_load !== 32'h0000FFFF) $display("FAIL clamp_load got=%h exp=0000ffff", o_load); else passed++;
        @(negedge clk);
        i_valid = 1'b0; #1;
        total++; if (o_s !== 5'd16) $display("FAIL clamp_ptr got=%0d exp=16", o_s); else passed++;
    endtask

    initial begin
        test_reset();
        test_p8();
        test_p5_wrap();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_prec_clamp();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
